// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: top-level sequencer for the in-place radix-2 DIT FFT engine.
// Loads MAX_N host samples into bank 0 in bit-reversed order, then re-arms the
// DIT address generator and issues one butterfly per cycle. Each butterfly
// write-back is delayed by BF_LATENCY cycles, the ping-pong banks are swapped
// between stages, and the result is streamed out in natural order.
// Optional build macro: FFT_SEQ_CTRL_CHECK_EN adds the sticky AGU
// consistency checker that drives o_err; without it o_err is tied low.
module fft_seq_ctrl #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int BF_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_load_we,
    output logic [ADDR_WIDTH-1:0] o_load_addr,
    output logic                  o_agu_reset_n,
    output logic                  o_next_step,
    input  logic                  i_agu_done_stage,
    input  logic                  i_agu_done_fft,
    output logic                  o_wb_we,
    output logic                  o_bank_sel,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    // Counters carry one extra bit so terminal compares never alias on wrap.
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int LOG2N = $clog2(MAX_N);

    localparam logic [CW-1:0] LAST_SAMPLE = CW'(MAX_N - 1);
    localparam logic [CW-1:0] LAST_BFLY   = CW'(MAX_N / 2 - 1);
    localparam logic [CW-1:0] LAST_STAGE  = CW'(LOG2N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_ISSUE,
        S_DRAIN,
        S_SWAP,
        S_UNLOAD
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CW-1:0]         r_loadCnt;
    logic [CW-1:0]         r_bflyCnt;
    logic [CW-1:0]         r_stageCnt;
    logic [CW-1:0]         r_outCnt;
    logic                  r_bankSel;
    logic [BF_LATENCY-1:0] r_wbPipe;
    logic [BF_LATENCY-1:0] w_pipeShift;
    logic                  w_inReady;
    logic                  w_nextStep;
    logic                  w_outValid;
    logic                  w_armStrobe;
    logic                  w_loadHs;
    logic                  w_outHs;
    logic [ADDR_WIDTH-1:0] w_loadAddr;

    // Contents of the write-back pipe after the next edge when nothing new is
    // shifted in; DRAIN ends once this is empty.
    assign w_pipeShift = r_wbPipe << 1;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and the per-state strobes.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_nextStep  = 1'b0;
        w_outValid  = 1'b0;
        w_armStrobe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                w_inReady = 1'b1;
                if (i_in_valid && (r_loadCnt == LAST_SAMPLE)) begin
                    w_nextState = S_ARM;
                end
            end
            S_ARM: begin
                w_armStrobe = 1'b1;
                w_nextState = S_ISSUE;
            end
            S_ISSUE: begin
                w_nextStep = 1'b1;
                if (r_bflyCnt == LAST_BFLY) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipeShift == '0) begin
                    w_nextState = S_SWAP;
                end
            end
            S_SWAP: begin
                if (r_stageCnt == LAST_STAGE) begin
                    w_nextState = S_UNLOAD;
                end else begin
                    w_nextState = S_ISSUE;
                end
            end
            S_UNLOAD: begin
                w_outValid = 1'b1;
                if (i_out_ready && (r_outCnt == LAST_SAMPLE)) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_loadHs = i_in_valid & w_inReady;
    assign w_outHs  = w_outValid & i_out_ready;

    // Load, butterfly, stage and unload counters plus the bank select; every
    // counter only moves on its own handshake or issue cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loadCnt  <= '0;
            r_bflyCnt  <= '0;
            r_stageCnt <= '0;
            r_outCnt   <= '0;
            r_bankSel  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_loadCnt  <= '0;
                        r_bflyCnt  <= '0;
                        r_stageCnt <= '0;
                        r_outCnt   <= '0;
                        r_bankSel  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_loadHs) begin
                        r_loadCnt <= r_loadCnt + 1'b1;
                    end
                end
                S_ARM: begin
                    r_bflyCnt <= '0;
                end
                S_ISSUE: begin
                    r_bflyCnt <= r_bflyCnt + 1'b1;
                end
                S_SWAP: begin
                    r_bankSel  <= ~r_bankSel;
                    r_stageCnt <= r_stageCnt + 1'b1;
                    r_bflyCnt  <= '0;
                end
                S_UNLOAD: begin
                    if (w_outHs) begin
                        r_outCnt <= r_outCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write-back delay line: each issue strobe re-emerges BF_LATENCY cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbPipe <= '0;
        end else begin
            r_wbPipe <= w_pipeShift | BF_LATENCY'(w_nextStep);
        end
    end

    // Bank-0 load address is the bit-reverse of the load count.
    always_comb begin
        w_loadAddr = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            w_loadAddr[i] = r_loadCnt[ADDR_WIDTH-1-i];
        end
    end

    assign o_in_ready    = w_inReady;
    assign o_load_we     = w_loadHs;
    assign o_load_addr   = w_loadAddr;
    assign o_agu_reset_n = i_rst_n & ~w_armStrobe;
    assign o_next_step   = w_nextStep;
    assign o_wb_we       = r_wbPipe[BF_LATENCY-1];
    assign o_bank_sel    = r_bankSel;
    assign o_out_valid   = w_outValid;
    assign o_out_addr    = r_outCnt[ADDR_WIDTH-1:0];
    assign o_out_last    = w_outValid & (r_outCnt == LAST_SAMPLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = w_outHs & (r_outCnt == LAST_SAMPLE);

`ifdef FFT_SEQ_CTRL_CHECK_EN
    logic r_lastStepSeen;
    logic r_inUnload;
    logic r_err;

    // Sticky AGU cross-check: done_stage must follow each stage's final issue,
    // and done_fft must already be up when unloading begins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lastStepSeen <= 1'b0;
            r_inUnload     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_lastStepSeen <= (r_state == S_ISSUE) && (r_bflyCnt == LAST_BFLY);
            r_inUnload     <= (r_state == S_UNLOAD);
            if (r_lastStepSeen && !i_agu_done_stage) begin
                r_err <= 1'b1;
            end
            if ((r_state == S_UNLOAD) && !r_inUnload && !i_agu_done_fft) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    logic w_unusedAgu;
    assign w_unusedAgu = i_agu_done_stage ^ i_agu_done_fft;
    assign o_err       = 1'b0;
`endif

endmodule
